// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between an upstream stage, this stage register and the downstream stage.
// master drives upstream data/flush and downstream ready; slave is the stage register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload + control with valid/ready, flush and bubble zeroing; 1-cycle latency.
// Backpressure: SKID=1 holds up to two items behind a registered in_ready, SKID=0 passes out_ready through.
// Optional PIPE_STAGE_PERF_CNT_EN adds saturating stall/bubble/flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      bus
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          bubble_cnt,
    output logic [7:0]           flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_state_nxt;
            logic              r_in_ready;
            logic [DATA_W-1:0] r_main_data;
            logic [CTRL_W-1:0] r_main_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic              w_accept;
            logic              w_emit;
            logic              w_ld_main_in;
            logic              w_ld_main_skid;
            logic              w_ld_skid;
            logic              w_clr_main;

            assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
            assign w_emit   = (r_state != ST_EMPTY) & bus.out_ready;

            always_comb begin
                w_state_nxt    = r_state;
                w_ld_main_in   = 1'b0;
                w_ld_main_skid = 1'b0;
                w_ld_skid      = 1'b0;
                w_clr_main     = 1'b0;
                if (bus.flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_clr_main  = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_state_nxt  = ST_ONE;
                                w_ld_main_in = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_emit) begin
                                w_ld_main_in = 1'b1;
                            end else if (w_accept) begin
                                w_state_nxt = ST_TWO;
                                w_ld_skid   = 1'b1;
                            end else if (w_emit) begin
                                w_state_nxt = ST_EMPTY;
                                w_clr_main  = 1'b1;
                            end
                        end
                        ST_TWO: begin
                            // in_ready is low here, so only the drain move is possible
                            if (w_emit) begin
                                w_state_nxt    = ST_ONE;
                                w_ld_main_skid = 1'b1;
                            end
                        end
                        default: w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main_data <= '0;
                    r_main_ctrl <= '0;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end else begin
                    if (w_ld_main_in) begin
                        r_main_data <= bus.in_data;
                        r_main_ctrl <= bus.in_ctrl;
                    end else if (w_ld_main_skid) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end else if (w_clr_main) begin
                        r_main_ctrl <= '0;
                    end
                    if (w_ld_skid) begin
                        r_skid_data <= bus.in_data;
                        r_skid_ctrl <= bus.in_ctrl;
                    end else if (bus.flush) begin
                        r_skid_data <= '0;
                        r_skid_ctrl <= '0;
                    end
                end
            end

            assign bus.in_ready  = r_in_ready;
            assign bus.out_valid = (r_state != ST_EMPTY);
            assign bus.out_data  = r_main_data;
            assign bus.out_ctrl  = r_main_ctrl;
        end else begin : g_noskid
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic [CTRL_W-1:0] r_ctrl;
            logic              w_in_ready;
            logic              w_accept;
            logic              w_emit;

            assign w_in_ready = ~r_valid | bus.out_ready;
            assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;
            assign w_emit     = r_valid & bus.out_ready;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_ctrl  <= '0;
                end else if (bus.flush) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_data  <= bus.in_data;
                    r_ctrl  <= bus.in_ctrl;
                end else if (w_emit) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end
            end

            assign bus.in_ready  = w_in_ready;
            assign bus.out_valid = r_valid;
            assign bus.out_data  = r_data;
            assign bus.out_ctrl  = r_ctrl;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (!bus.out_valid && (bubble_cnt != 16'hFFFF))
                bubble_cnt <= bubble_cnt + 16'd1;
            if (bus.flush && (flush_cnt != 8'hFF))
                flush_cnt <= flush_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance checked every cycle against a queue model.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) bus0 ();

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [15:0] stall1, bubble1, stall0, bubble0;
    logic [7:0]  flushc1, flushc0;
`endif

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .stall_cnt(stall1), .bubble_cnt(bubble1), .flush_cnt(flushc1)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .stall_cnt(stall0), .bubble_cnt(bubble0), .flush_cnt(flushc0)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: each stage is an ordered queue of held {data,ctrl} items.
    logic [35:0] q1[$];
    logic [35:0] q0[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1.delete();
            q0.delete();
        end else begin
            bit rdy1, rdy0, acc_1, acc_0, em_1, em_0;
            rdy1  = (q1.size() < 2);
            rdy0  = (q0.size() == 0) || bus0.out_ready;
            em_1  = (q1.size() > 0) && bus1.out_ready;
            em_0  = (q0.size() > 0) && bus0.out_ready;
            acc_1 = bus1.in_valid && rdy1 && !bus1.flush;
            acc_0 = bus0.in_valid && rdy0 && !bus0.flush;
            if (bus1.flush) q1.delete();
            else begin
                if (em_1) void'(q1.pop_front());
                if (acc_1) q1.push_back({bus1.in_data, bus1.in_ctrl});
            end
            if (bus0.flush) q0.delete();
            else begin
                if (em_0) void'(q0.pop_front());
                if (acc_0) q0.push_back({bus0.in_data, bus0.in_ctrl});
            end
        end
    end

    // Per-cycle comparison against the model, plus DUT emit counters.
    int em1 = 0;
    int em0 = 0;
    always @(negedge clk) begin
        if (rst) begin
            logic [35:0] h;
            check("s1_in_ready", bus1.in_ready, q1.size() < 2);
            check("s1_out_valid", bus1.out_valid, q1.size() > 0);
            if (q1.size() > 0) begin
                h = q1[0];
                check("s1_out_data", bus1.out_data, h[35:4]);
                check("s1_out_ctrl", bus1.out_ctrl, h[3:0]);
            end else check("s1_bubble_ctrl", bus1.out_ctrl, 0);
            check("s0_in_ready", bus0.in_ready, (q0.size() == 0) || bus0.out_ready);
            check("s0_out_valid", bus0.out_valid, q0.size() > 0);
            if (q0.size() > 0) begin
                h = q0[0];
                check("s0_out_data", bus0.out_data, h[35:4]);
                check("s0_out_ctrl", bus0.out_ctrl, h[3:0]);
            end else check("s0_bubble_ctrl", bus0.out_ctrl, 0);
            if (bus1.out_valid && bus1.out_ready) em1++;
            if (bus0.out_valid && bus0.out_ready) em0++;
        end
    end

    bit acc1, acc0;
    task automatic cyc();
        @(negedge clk);
        acc1 = bus1.in_valid && bus1.in_ready && !bus1.flush;
        acc0 = bus0.in_valid && bus0.in_ready && !bus0.flush;
        @(posedge clk);
        #1;
    endtask

    task automatic put1(input logic v, input logic [31:0] d, input logic [3:0] c);
        bus1.in_valid = v;
        bus1.in_data  = d;
        bus1.in_ctrl  = c;
    endtask

    initial begin
        int e0, e1, sent, n;
        put1(1'b0, '0, '0);
        bus1.flush = 1'b0; bus1.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctrl = '0;
        bus0.flush = 1'b0; bus0.out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        check("rst_in_ready1", bus1.in_ready, 1);
        check("rst_out_valid1", bus1.out_valid, 0);
        check("rst_out_data1", bus1.out_data, 0);
        check("rst_out_ctrl1", bus1.out_ctrl, 0);
        check("rst_in_ready0", bus0.in_ready, 1);

        // Reset mid-stream with two items held
        bus1.out_ready = 1'b0;
        put1(1'b1, 32'h11, 4'h1); cyc();
        put1(1'b1, 32'h22, 4'h2); cyc();
        put1(1'b0, '0, '0);
        check("mid_held_data", bus1.out_data, 32'h11);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_valid", bus1.out_valid, 0);
        check("mid_rst_ctrl", bus1.out_ctrl, 0);
        check("mid_rst_data", bus1.out_data, 0);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        check("mid_rel_in_ready", bus1.in_ready, 1);
        bus1.out_ready = 1'b1;
        cyc();

        // Single item
        put1(1'b1, 32'hDEADBEEF, 4'hA); cyc();
        put1(1'b0, '0, '0);
        check("single_valid", bus1.out_valid, 1);
        check("single_data", bus1.out_data, 32'hDEADBEEF);
        check("single_ctrl", bus1.out_ctrl, 4'hA);
        cyc();
        check("single_after_valid", bus1.out_valid, 0);
        check("single_after_ctrl", bus1.out_ctrl, 0);

        // Back-pressure: 1,2 held, 3 refused, then drained in order
        bus1.out_ready = 1'b0;
        put1(1'b1, 32'd1, 4'h1); cyc();
        put1(1'b1, 32'd2, 4'h2); cyc();
        check("bp_in_ready_two", bus1.in_ready, 0);
        put1(1'b1, 32'd3, 4'h3); cyc();
        check("bp_3_refused", acc1, 0);
        check("bp_hold_data", bus1.out_data, 32'd1);
        bus1.out_ready = 1'b1;
        cyc();
        check("bp_out2", bus1.out_data, 32'd2);
        cyc();
        check("bp_3_accepted", acc1, 1);
        check("bp_out3", bus1.out_data, 32'd3);
        put1(1'b0, '0, '0);
        cyc();
        check("bp_drained", bus1.out_valid, 0);

        // Flush while TWO with 0x55 offered
        bus1.out_ready = 1'b0;
        put1(1'b1, 32'hA1, 4'h5); cyc();
        put1(1'b1, 32'hA2, 4'h6); cyc();
        put1(1'b1, 32'h55, 4'hF);
        bus1.flush = 1'b1; cyc();
        bus1.flush = 1'b0; put1(1'b0, '0, '0);
        check("flush_valid", bus1.out_valid, 0);
        check("flush_ctrl", bus1.out_ctrl, 0);
        check("flush_in_ready", bus1.in_ready, 1);
        bus1.out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus1.out_valid) n++;
        end
        check("flush_55_gone", n, 0);

        // Full throughput on SKID=1: 100 items in 101 cycles
        e1 = em1;
        for (int i = 0; i < 100; i++) begin
            put1(1'b1, 32'h100 + i, 4'(i)); cyc();
        end
        put1(1'b0, '0, '0); cyc();
        check("thru_emits", em1 - e1, 100);
        check("thru_empty", bus1.out_valid, 0);

        // SKID=0 combinational ready
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 32'h7; bus0.in_ctrl = 4'h7; cyc();
        bus0.in_valid = 1'b0;
        #1;
        check("s0_ready_stall", bus0.in_ready, 0);
        bus0.out_ready = 1'b1;
        #1;
        check("s0_ready_pass", bus0.in_ready, 1);
        cyc();

        // SKID=0, random out_ready, 100 ordered items (bounded)
        e0 = em0; sent = 0;
        for (int c = 0; c < 2000 && (em0 - e0) < 100; c++) begin
            bus0.in_valid  = (sent < 100);
            bus0.in_data   = 32'h1000 + sent;
            bus0.in_ctrl   = 4'(sent);
            bus0.out_ready = 1'($urandom_range(0, 1));
            cyc();
            if (acc0) sent++;
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        check("s0_rand_emits", em0 - e0, 100);
        cyc();

`ifdef PIPE_STAGE_PERF_CNT_EN
        rst = 1'b0; cyc(); rst = 1'b1;
        bus1.out_ready = 1'b0;
        put1(1'b1, 32'h77, 4'h7); cyc();
        put1(1'b0, '0, '0);
        for (int i = 0; i < 70000; i++) cyc();
        check("perf_stall_sat", stall1, 16'hFFFF);
        check("perf_bubble_sat0", bubble0, 16'hFFFF);
        bus1.flush = 1'b1; bus0.flush = 1'b1; cyc();
        bus1.flush = 1'b0; bus0.flush = 1'b0; cyc();
        bus1.flush = 1'b1; cyc();
        bus1.flush = 1'b0; cyc();
        check("perf_flush1", flushc1, 2);
        check("perf_flush0", flushc0, 1);
        check("perf_stall_kept", stall1, 16'hFFFF);
        bus1.out_ready = 1'b1;
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
